mul_share_arb: RTL and testbench
================================

MUL_SHARE_ARB -- requirements
Module: mul_share_arb

Interface
REQ-001 Parameter: W, default 4, operand width in bits; product width is 2W.
REQ-002 Port: clk  in  1  single clock, all state updates on rising edge.
REQ-003 Port: reset  in  1  asynchronous, active-high reset.
REQ-004 Port: req0_valid  in  1  requester 0 has an operand pair.
REQ-005 Port: req0_ready  out  1  requester 0 pair accepted this cycle when valid&ready.
REQ-006 Port: req0_x, req0_y  in  W each  requester 0 unsigned operands.
REQ-007 Port: req1_valid, req1_ready, req1_x, req1_y  as REQ-004..006 for requester 1.
REQ-008 Port: rsp_valid  out  1  result register holds an undelivered product.
REQ-009 Port: rsp_ready  in  1  consumer takes result when valid&ready.
REQ-010 Port: rsp_tag  out  1  index of requester that owns the result.
REQ-011 Port: rsp_p  out  2W  unsigned product X*Y.

Function
REQ-012 Block SHALL time-share one combinational WxW multiplier between the two requesters.
REQ-013 FSM states: IDLE (result register empty) and HOLD (result register full).
REQ-014 Accept-enable ACC = (state==IDLE) | (state==HOLD & rsp_valid & rsp_ready).
REQ-015 Grant: only one valid -> that requester; both valid -> requester indexed by priority pointer prio.
REQ-016 reqN_ready SHALL be 1 only for the granted requester and only when ACC=1; never both high.
REQ-017 On accept: rsp_p <= x*y of winner, rsp_tag <= winner index, state <= HOLD at the next edge (latency 1 cycle accept-to-rsp_valid).
REQ-018 On accept: prio <= complement of winner index (round-robin); no accept -> prio holds.
REQ-019 HOLD with rsp handshake and no accept -> IDLE; HOLD with handshake and accept -> stays HOLD with new result (back-to-back, 1 result/cycle).
REQ-020 HOLD without rsp handshake: rsp_valid, rsp_tag, rsp_p SHALL stay stable; both req ready low.
REQ-021 Product SHALL be exact, full 2W bits, unsigned, no truncation or correction constant.
REQ-022 rsp_valid = (state==HOLD); reqN_ready depends combinationally on reqN_valid, state, rsp_ready.
REQ-023 Requester changing operands while valid&!ready SHALL not affect the registered result.

Reset
REQ-024 Reset asserted SHALL immediately force state=IDLE, rsp_valid=0, rsp_tag=0, rsp_p=0, prio=0.
REQ-025 Reset mid-HOLD SHALL discard the pending result; no handshake in the reset cycle counts.
REQ-026 First grant after reset with both valid SHALL go to requester 0.

Structure
REQ-027 Shared package holds W default, state enumeration (IDLE, HOLD), and tag width constant.
REQ-028 One sub-module mul_array: combinational unsigned WxW -> 2W array multiplier, no state.
REQ-029 Arbiter, FSM and result register SHALL live in mul_share_arb; target 120-400 lines RTL.

Verification
REQ-030 Reset, req0 x=3 y=5 valid, rsp_ready=1 -> req0_ready=1 cycle 0; rsp_valid=1, tag=0, p=15 cycle 1.
REQ-031 Both valid after reset (x0=15,y0=15; x1=2,y1=7), rsp_ready=1 -> results tag0 p=225, then tag1 p=14 on consecutive cycles.
REQ-032 rsp_ready=0 for 4 cycles while HOLD tag1 p=14 -> rsp outputs stable, req0/req1_ready=0; release -> delivered once.
REQ-033 Both valid continuously 8 cycles, rsp_ready=1 -> tags alternate 0,1,0,1...; 8 results, no bubbles.
REQ-034 Reset asserted in HOLD (p=225) -> rsp_valid=0, rsp_p=0 same cycle; after release next grant with both valid is req0.
REQ-035 Exhaustive W=4 sweep via req1 only: every x,y in 0..15 -> rsp_p = x*y, tag=1.

Source files
------------

// File: rtl/mul_share_arb_pkg.sv
// Shared constants and state encoding for the two-requester shared multiplier.
package mul_share_arb_pkg;

  localparam int unsigned MSA_W = 4;
  localparam int unsigned TAG_W = 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

endpackage

// File: rtl/mul_share_arb_mul_array.sv
// Purely combinational unsigned WxW -> 2W shift-and-add array multiplier.
module mul_array #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  output logic [2*W-1:0] p_o
);

  logic [2*W-1:0] a_ext;

  always_comb begin
    a_ext = {{W{1'b0}}, a_i};
    p_o   = '0;
    for (int unsigned i = 0; i < W; i++) begin
      if (b_i[i]) p_o = p_o + (a_ext << i);
    end
  end

endmodule

// File: rtl/mul_share_arb.sv
// Two requesters time-share one multiplier; round-robin grant, single result register.
module mul_share_arb
  import mul_share_arb_pkg::*;
#(
  parameter int unsigned W = MSA_W
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [W-1:0]   req0_x,
  input  logic [W-1:0]   req0_y,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [W-1:0]   req1_x,
  input  logic [W-1:0]   req1_y,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic           rsp_tag,
  output logic [2*W-1:0] rsp_p
);

  state_e             state_q, state_d;
  logic [TAG_W-1:0]   prio_q, prio_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [2*W-1:0]     p_q, p_d;

  logic               acc;
  logic               any_valid;
  logic               accept;
  logic [TAG_W-1:0]   win;
  logic [W-1:0]       op_x, op_y;
  logic [2*W-1:0]     prod;

  // Accept when empty, or when the held result leaves in this same cycle.
  always_comb begin
    acc       = (state_q == IDLE) || ((state_q == HOLD) && rsp_ready);
    any_valid = req0_valid || req1_valid;
    accept    = acc && any_valid;
    if (req0_valid && req1_valid) win = prio_q;
    else                          win = req1_valid;
    req0_ready = acc && req0_valid && (win == 1'b0);
    req1_ready = acc && req1_valid && (win == 1'b1);
    op_x = (win == 1'b1) ? req1_x : req0_x;
    op_y = (win == 1'b1) ? req1_y : req0_y;
  end

  mul_array #(.W(W)) u_mul (
    .a_i (op_x),
    .b_i (op_y),
    .p_o (prod)
  );

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    tag_d   = tag_q;
    p_d     = p_q;
    if (accept) begin
      state_d = HOLD;
      prio_d  = ~win;
      tag_d   = win;
      p_d     = prod;
    end else if ((state_q == HOLD) && rsp_ready) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      prio_q  <= '0;
      tag_q   <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      tag_q   <= tag_d;
      p_q     <= p_d;
    end
  end

  assign rsp_valid = (state_q == HOLD);
  assign rsp_tag   = tag_q;
  assign rsp_p     = p_q;

endmodule

// File: tb/tb_mul_share_arb.sv
// Directed self-checking bench for mul_share_arb at W=4.
module tb_mul_share_arb;

  logic       clk;
  logic       reset;
  logic       req0_valid, req0_ready;
  logic [3:0] req0_x, req0_y;
  logic       req1_valid, req1_ready;
  logic [3:0] req1_x, req1_y;
  logic       rsp_valid, rsp_ready, rsp_tag;
  logic [7:0] rsp_p;

  int errors = 0;
  int checks = 0;

  mul_share_arb #(.W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_x     (req0_x),
    .req0_y     (req0_y),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_x     (req1_x),
    .req1_y     (req1_y),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_tag    (rsp_tag),
    .rsp_p      (rsp_p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0; req0_x = '0; req0_y = '0;
    req1_valid = 1'b0; req1_x = '0; req1_y = '0;
    rsp_ready  = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    #2;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_tag !== 1'b0 || rsp_p !== 8'd0) begin
      errors++;
      $display("FAIL reset_state: valid=%b tag=%b p=%0d want 0 0 0", rsp_valid, rsp_tag, rsp_p);
    end
    step();
    reset = 1'b0;
    #1;
    checks++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: r0=%b r1=%b want 0 0", req0_ready, req1_ready);
    end
  endtask

  task automatic test_single();
    do_reset();
    req0_valid = 1'b1; req0_x = 4'd3; req0_y = 4'd5; rsp_ready = 1'b1;
    #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL single_ready: r0=%b r1=%b want 1 0", req0_ready, req1_ready);
    end
    step();
    req0_valid = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_tag !== 1'b0 || rsp_p !== 8'd15) begin
      errors++;
      $display("FAIL single_rsp: valid=%b tag=%b p=%0d want 1 0 15", rsp_valid, rsp_tag, rsp_p);
    end
    step();
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_drain: valid=%b want 0", rsp_valid);
    end
  endtask

  // Both valid after reset, then the tag1 result is stalled for 4 cycles.
  task automatic test_both_and_stall();
    do_reset();
    req0_valid = 1'b1; req0_x = 4'd15; req0_y = 4'd15;
    req1_valid = 1'b1; req1_x = 4'd2;  req1_y = 4'd7;
    rsp_ready  = 1'b1;
    #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL both_first_grant: r0=%b r1=%b want 1 0", req0_ready, req1_ready);
    end
    step();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_tag !== 1'b0 || rsp_p !== 8'd225 ||
        req0_ready !== 1'b0 || req1_ready !== 1'b1) begin
      errors++;
      $display("FAIL both_rsp0: valid=%b tag=%b p=%0d r0=%b r1=%b want 1 0 225 0 1",
               rsp_valid, rsp_tag, rsp_p, req0_ready, req1_ready);
    end
    step();
    req1_valid = 1'b0;
    rsp_ready  = 1'b0;
    req0_x = 4'd1; req0_y = 4'd1;
    #1;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_tag !== 1'b1 || rsp_p !== 8'd14) begin
      errors++;
      $display("FAIL both_rsp1: valid=%b tag=%b p=%0d want 1 1 14", rsp_valid, rsp_tag, rsp_p);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      req0_x = 4'(i + 5); req0_y = 4'(9 - i);
      #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_tag !== 1'b1 || rsp_p !== 8'd14 ||
          req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_%0d: valid=%b tag=%b p=%0d r0=%b r1=%b want 1 1 14 0 0",
                 i, rsp_valid, rsp_tag, rsp_p, req0_ready, req1_ready);
      end
    end
    req0_valid = 1'b0;
    rsp_ready  = 1'b1;
    step();
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_release: valid=%b want 0", rsp_valid);
    end
    rsp_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic       exp_tag;
    logic [7:0] exp_p;
    do_reset();
    rsp_ready  = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      req0_x = 4'(i);      req0_y = 4'(i + 1);
      req1_x = 4'(15 - i); req1_y = 4'(i + 2);
      exp_tag = 1'(i % 2);
      exp_p   = exp_tag ? 8'((15 - i) * (i + 2)) : 8'(i * (i + 1));
      #1;
      checks++;
      if (req0_ready !== ~exp_tag || req1_ready !== exp_tag) begin
        errors++;
        $display("FAIL b2b_grant_%0d: r0=%b r1=%b want %b %b",
                 i, req0_ready, req1_ready, ~exp_tag, exp_tag);
      end
      step();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_tag !== exp_tag || rsp_p !== exp_p) begin
        errors++;
        $display("FAIL b2b_rsp_%0d: valid=%b tag=%b p=%0d want 1 %b %0d",
                 i, rsp_valid, rsp_tag, rsp_p, exp_tag, exp_p);
      end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    step();
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain: valid=%b want 0", rsp_valid);
    end
  endtask

  task automatic test_reset_hold();
    do_reset();
    req0_valid = 1'b1; req0_x = 4'd15; req0_y = 4'd15;
    req1_valid = 1'b1; req1_x = 4'd2;  req1_y = 4'd7;
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_p !== 8'd225) begin
      errors++;
      $display("FAIL rsthold_pre: valid=%b p=%0d want 1 225", rsp_valid, rsp_p);
    end
    #1;
    reset = 1'b1;
    rsp_ready = 1'b1;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_p !== 8'd0 || rsp_tag !== 1'b0) begin
      errors++;
      $display("FAIL rsthold_clear: valid=%b tag=%b p=%0d want 0 0 0", rsp_valid, rsp_tag, rsp_p);
    end
    step();
    reset = 1'b0;
    rsp_ready = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL rsthold_grant: r0=%b r1=%b want 1 0", req0_ready, req1_ready);
    end
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_tag !== 1'b0 || rsp_p !== 8'd225) begin
      errors++;
      $display("FAIL rsthold_rsp: valid=%b tag=%b p=%0d want 1 0 225", rsp_valid, rsp_tag, rsp_p);
    end
  endtask

  task automatic test_sweep();
    logic [7:0] exp_p;
    do_reset();
    rsp_ready  = 1'b1;
    req1_valid = 1'b1;
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        req1_x = 4'(x);
        req1_y = 4'(y);
        exp_p  = 8'(x * y);
        #1;
        checks++;
        if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
          errors++;
          $display("FAIL sweep_ready_%0d_%0d: r1=%b r0=%b want 1 0", x, y, req1_ready, req0_ready);
        end
        step();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_tag !== 1'b1 || rsp_p !== exp_p) begin
          errors++;
          $display("FAIL sweep_%0d_%0d: valid=%b tag=%b p=%0d want 1 1 %0d",
                   x, y, rsp_valid, rsp_tag, rsp_p, exp_p);
        end
      end
    end
    req1_valid = 1'b0;
    step();
  endtask

  initial begin
    idle_inputs();
    reset = 1'b0;
    #3;
    test_reset();
    test_single();
    test_both_and_stall();
    test_back_to_back();
    test_reset_hold();
    test_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
